// File: rtl/fast_square_pkg.sv
// Shared types and constants for the fast-square sweep controller.
// Feature macro used by the top: FAST_SQUARE_SWEEP_CONTINUOUS_EN.
package fast_square_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int STEP_W    = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_SETTLE,
      S_RECORD,
      S_STEP
   } sweep_state_e;

endpackage

// File: rtl/fast_square_strobe_counter.sv
// Saturating event counter with synchronous clear and a terminal-count hit flag.
// hit_o is high on the cycle the tc_i-th enabled event is seen.
module fast_square_strobe_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] tc_i,
   output logic             hit_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Widened compare so tc_i == 0 never hits and the all-ones count cannot wrap.
   assign hit_o = en_i && (({1'b0, count_q} + (CNT_W+1)'(1)) == {1'b0, tc_i});

endmodule

// File: rtl/fast_square_sweep_ctrl.sv
// Frequency-sweep sequencer for the fast-square comb/decimate chain: flush, settle, record, step.
// Define FAST_SQUARE_SWEEP_CONTINUOUS_EN for a free-running sweep that restarts after the last step.
module fast_square_sweep_ctrl
   import fast_square_pkg::*;
#(
   parameter int NUM_STEPS      = 32,
   parameter int FLUSH_CYCLES   = 4,
   parameter int SETTLE_STROBES = 202,
   parameter int RECORD_STROBES = 64,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              strobe_in,
   output logic              dsp_reset_out,
   output logic              record_out,
   output logic              freq_step_out,
   output logic [STEP_W-1:0] step_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   sweep_state_e      state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              done_q, done_d;
   logic              dsp_q, rec_q, fstep_q, busy_q;
   logic              cnt_clr, cnt_en, cnt_hit;
   logic [CNT_W-1:0]  cnt_tc;

   // One counter serves all timed states: clock cycles in FLUSH, strobes in SETTLE/RECORD.
   always_comb begin
      cnt_en = 1'b0;
      cnt_tc = CNT_W'(RECORD_STROBES);
      case (state_q)
         S_FLUSH: begin
            cnt_en = 1'b1;
            cnt_tc = CNT_W'(FLUSH_CYCLES);
         end
         S_SETTLE: begin
            cnt_en = strobe_in;
            cnt_tc = CNT_W'(SETTLE_STROBES);
         end
         S_RECORD: begin
            cnt_en = strobe_in;
            cnt_tc = CNT_W'(RECORD_STROBES);
         end
         default: ;
      endcase
   end

   assign cnt_clr = (state_d != state_q);

   fast_square_strobe_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clock (clock),
      .reset (reset),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .tc_i  (cnt_tc),
      .hit_o (cnt_hit)
   );

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FLUSH;
               step_d  = '0;
            end
         end
         S_FLUSH: begin
            if (cnt_hit) state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if ((SETTLE_STROBES == 0) || cnt_hit) state_d = S_RECORD;
         end
         S_RECORD: begin
            if (cnt_hit) state_d = S_STEP;
         end
         S_STEP: begin
            if (step_q == LAST_STEP) begin
               done_d = 1'b1;
`ifdef FAST_SQUARE_SWEEP_CONTINUOUS_EN
               state_d = S_FLUSH;
               step_d  = '0;
`else
               state_d = S_IDLE;
`endif
            end else begin
               state_d = S_FLUSH;
               step_d  = step_q + STEP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Abort overrides everything, including a simultaneous start or sweep completion.
      if (abort) begin
         state_d = S_IDLE;
         step_d  = step_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         done_q  <= 1'b0;
         dsp_q   <= 1'b0;
         rec_q   <= 1'b0;
         fstep_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         done_q  <= done_d;
         dsp_q   <= (state_d == S_FLUSH);
         rec_q   <= (state_d == S_RECORD);
         fstep_q <= (state_d == S_STEP);
         busy_q  <= (state_d != S_IDLE);
      end
   end

   assign dsp_reset_out = dsp_q;
   assign record_out    = rec_q;
   assign freq_step_out = fstep_q;
   assign step_idx      = step_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Directed self-checking bench for fast_square_sweep_ctrl (NUM_STEPS=2, FLUSH=4, SETTLE=3, RECORD=2).
// With FAST_SQUARE_SWEEP_CONTINUOUS_EN defined the free-running sweep is exercised instead of single sweeps.
module tb_fast_square_sweep_ctrl;

   localparam int NUM_STEPS      = 2;
   localparam int FLUSH_CYCLES   = 4;
   localparam int SETTLE_STROBES = 3;
   localparam int RECORD_STROBES = 2;
   localparam int CNT_W          = 16;
   localparam int BUDGET         = 400;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       strobe_in = 1'b0;
   logic       dsp_reset_out, record_out, freq_step_out, busy, done;
   logic [7:0] step_idx;

   int total = 0;
   int bad   = 0;

   // Scoreboard: expected step_idx for each freq_step_out pulse, in order.
   logic [7:0] exp_q[$];

   // Monitor totals (written only by the monitor).
   int         dsp_tot  = 0;
   int         rec_tot  = 0;
   int         fs_tot   = 0;
   int         done_tot = 0;
   logic [7:0] obs_idx [64];

   bit free_strobe = 1'b0;
   int phase = 0;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   fast_square_sweep_ctrl #(
      .NUM_STEPS      (NUM_STEPS),
      .FLUSH_CYCLES   (FLUSH_CYCLES),
      .SETTLE_STROBES (SETTLE_STROBES),
      .RECORD_STROBES (RECORD_STROBES),
      .CNT_W          (CNT_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .strobe_in     (strobe_in),
      .dsp_reset_out (dsp_reset_out),
      .record_out    (record_out),
      .freq_step_out (freq_step_out),
      .step_idx      (step_idx),
      .busy          (busy),
      .done          (done)
   );

   // Monitor sampled mid-cycle, away from the active edge.
   always @(negedge clock) begin
      if (dsp_reset_out) dsp_tot <= dsp_tot + 1;
      if (record_out && strobe_in) rec_tot <= rec_tot + 1;
      if (done) done_tot <= done_tot + 1;
      if (freq_step_out) begin
         if (fs_tot < 64) obs_idx[fs_tot] <= step_idx;
         fs_tot <= fs_tot + 1;
      end
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, expv);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic cyc();
      if (free_strobe) begin
         strobe_in = (phase == 3);
         phase = (phase + 1) % 4;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_dsp"}, dsp_reset_out, 0);
      check({tag, "_rec"}, record_out, 0);
      check({tag, "_fstep"}, freq_step_out, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   task automatic check_steps(input int f0, input int n);
      for (int k = 0; k < n; k++) begin
         if (exp_q.size() == 0) begin
            check("fstep_exp_empty", 1, 0);
         end else begin
            check("fstep_idx", obs_idx[f0 + k], exp_q.pop_front());
         end
      end
   endtask

   // One full single sweep; optionally pokes start once right after entering SETTLE.
   task automatic run_sweep(input bit poke);
      int  d0, r0, f0, n0, i;
      bit  was_dsp, poked;
      d0 = dsp_tot; r0 = rec_tot; f0 = fs_tot; n0 = done_tot;
      free_strobe = 1'b1;
      phase = 0;
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("sweep_latency_dsp", dsp_reset_out, 1);
      check("sweep_busy", busy, 1);
      check("sweep_first_idx", step_idx, 0);
      was_dsp = 1'b1;
      poked = 1'b0;
      i = 0;
      while ((done_tot == n0) && (i < BUDGET)) begin
         start = 1'b0;
         if (poke && !poked && was_dsp && !dsp_reset_out && busy) begin
            start = 1'b1;
            poked = 1'b1;
         end
         was_dsp = dsp_reset_out;
         cyc();
         i++;
      end
      start = 1'b0;
      check("sweep_timeout", (i < BUDGET), 1);
      if (poke) check("sweep_poked", poked, 1);
      repeat (6) cyc();
      free_strobe = 1'b0;
      strobe_in = 1'b0;
      check("sweep_dsp_cycles", dsp_tot - d0, NUM_STEPS * FLUSH_CYCLES);
      check("sweep_rec_strobes", rec_tot - r0, NUM_STEPS * RECORD_STROBES);
      check("sweep_fstep_count", fs_tot - f0, NUM_STEPS);
      check("sweep_done_count", done_tot - n0, 1);
      check("sweep_end_busy", busy, 0);
      check("sweep_end_idx", step_idx, NUM_STEPS - 1);
      check_steps(f0, NUM_STEPS);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int f0, n0, i;

      // reset state
      repeat (3) @(posedge clock);
      #1;
      check_quiet("reset");
      check("reset_idx", step_idx, 0);
      reset = 1'b1;
      cyc();
      check("idle_busy", busy, 0);

      // abort and start together in IDLE: abort wins
      start = 1'b1;
      abort = 1'b1;
      cyc();
      start = 1'b0;
      abort = 1'b0;
      check_quiet("abort_start");
      cyc();
      check("abort_start_later_busy", busy, 0);

      // strobe during the whole FLUSH (including its last cycle) is not counted in SETTLE
      n0 = done_tot;
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("flush_latency", dsp_reset_out, 1);
      strobe_in = 1'b1;
      repeat (FLUSH_CYCLES - 1) cyc();
      check("flush_last_cycle_hi", dsp_reset_out, 1);
      cyc();
      check("flush_end_lo", dsp_reset_out, 0);
      check("settle_busy", busy, 1);
      strobe_in = 1'b1; cyc();
      strobe_in = 1'b0; cyc();
      strobe_in = 1'b1; cyc();
      strobe_in = 1'b0; cyc();
      check("settle_two_strobes_no_rec", record_out, 0);
      strobe_in = 1'b1; cyc();
      strobe_in = 1'b0;
      check("settle_third_strobe_rec", record_out, 1);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check_quiet("abort_record");
      check("abort_idx_held", step_idx, 0);
      check("abort_no_done", done_tot - n0, 0);

`ifndef FAST_SQUARE_SWEEP_CONTINUOUS_EN
      // plain sweep, then a sweep with a start pulse during SETTLE
      run_sweep(1'b0);
      run_sweep(1'b1);
`endif

      // async reset during RECORD of step 1
      f0 = fs_tot;
      n0 = done_tot;
      exp_q.push_back(8'd0);
      free_strobe = 1'b1;
      phase = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      i = 0;
      while (!(record_out && (step_idx == 8'd1)) && (i < BUDGET)) begin
         cyc();
         i++;
      end
      check("rst_reach_timeout", (i < BUDGET), 1);
      free_strobe = 1'b0;
      strobe_in = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_quiet("rst_async");
      check("rst_async_idx", step_idx, 0);
      cyc();
      cyc();
      reset = 1'b1;
      repeat (5) cyc();
      check("rst_no_done", done_tot - n0, 0);
      check("rst_end_busy", busy, 0);
      check("rst_fstep_count", fs_tot - f0, 1);
      check_steps(f0, 1);

`ifdef FAST_SQUARE_SWEEP_CONTINUOUS_EN
      // free-running sweep: two completions, indices 0,1,0,1, then abort
      f0 = fs_tot;
      n0 = done_tot;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(8'd0);
         exp_q.push_back(8'd1);
      end
      free_strobe = 1'b1;
      phase = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      i = 0;
      while ((done_tot - n0 < 2) && (i < BUDGET)) begin
         cyc();
         i++;
      end
      check("cont_timeout", (i < BUDGET), 1);
      check("cont_done_count", done_tot - n0, 2);
      check("cont_fstep_count", fs_tot - f0, 4);
      check("cont_still_busy", busy, 1);
      check("cont_restart_idx", step_idx, 0);
      check_steps(f0, 4);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      free_strobe = 1'b0;
      strobe_in = 1'b0;
      check_quiet("cont_abort");
      repeat (3) cyc();
      check("cont_abort_stays_idle", busy, 0);
`endif

      check("scoreboard_left", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
